// File: rtl/fpu_useq_pkg.sv
// fpu_useq_pkg: shared definitions for the FPU microcode sequencer.
//   a2func_e : sequencing function carried by every microword (a2func field)
package fpu_useq_pkg;

  typedef enum logic [2:0] {
    SEQ   = 3'd0,  // unconditional jump to nxcode
    CBR   = 3'd1,  // conditional branch on cond
    LDCNT = 3'd2,  // load loop counter from nxcode
    LOOP  = 3'd3,  // decrement-and-branch while counter non-zero
    CALL  = 3'd4,  // push return address, jump to nxcode
    RET   = 3'd5,  // pop return address
    RSVD  = 3'd6,  // reserved, treated as SEQ
    END   = 3'd7   // terminate op, return to address 0
  } a2func_e;

endpackage

// File: rtl/fpu_useq_lstack.sv
// fpu_useq_lstack: link stack for microcode CALL/RET.
//   clk         : clock, rising edge
//   push / pop  : push din / pop top (one at a time)
//   clr         : synchronous clear of occupancy (dominates push/pop)
//   din         : return address to push
//   top         : combinational top-of-stack
//   sp          : occupancy, 0..STACK_DEPTH
//   ovf / unf   : combinational: push while full / pop while empty
// Entries live in a packed shift register with the top at the low end, so
// push/pop are plain shifts and no occupancy-indexed addressing is needed.
module fpu_useq_lstack #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic                               clk,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               clr,
  input  logic [ADDR_W-1:0]                  din,
  output logic [ADDR_W-1:0]                  top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               ovf,
  output logic                               unf
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned STK_W = STACK_DEPTH * ADDR_W;

  logic [STK_W-1:0] stk_q;
  logic [SP_W-1:0]  sp_q;
  logic             full;
  logic             empty;

  assign full  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty = (sp_q == '0);
  assign ovf   = push & full;
  assign unf   = pop & empty;
  assign top   = stk_q[ADDR_W-1:0];
  assign sp    = sp_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sp_q <= '0;
    end else if (push && !full) begin
      // Truncating cast drops the bottom entry's slot, which is unused here.
      stk_q <= STK_W'({stk_q, din});
      sp_q  <= sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      stk_q <= stk_q >> ADDR_W;
      sp_q  <= sp_q - SP_W'(1);
    end
  end

endmodule

// File: rtl/fpu_useq.sv
// fpu_useq: FPU microcode sequencer; produces the ROM address every cycle.
//   clk, reset_l        : clock; synchronous active-low reset
//   fpuhold             : freeze all state, ROM re-reads pc
//   fpkill              : abort op, return to idle (stack_err kept)
//   op_look, op_valid   : dispatch mapadd when both high
//   mapadd              : dispatch address from opcode map
//   a2func, nxcode      : sequencing function / target of current microword
//   cond                : CBR condition
//   code_add            : combinational ROM address for next cycle
//   rom_en              : ROM enable (low while holding)
//   pc                  : address of microword at ROM output
//   busy                : op in progress
//   erop                : current microword is END
//   stack_err           : sticky link-stack overflow/underflow
//   sp                  : link-stack occupancy
module fpu_useq
  import fpu_useq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned CNT_W       = 6
) (
  input  logic                              clk,
  input  logic                              reset_l,
  input  logic                              fpuhold,
  input  logic                              fpkill,
  input  logic                              op_look,
  input  logic                              op_valid,
  input  logic [ADDR_W-1:0]                 mapadd,
  input  logic [2:0]                        a2func,
  input  logic [ADDR_W-1:0]                 nxcode,
  input  logic                              cond,
  output logic [ADDR_W-1:0]                 code_add,
  output logic                              rom_en,
  output logic [ADDR_W-1:0]                 pc,
  output logic                              busy,
  output logic                              erop,
  output logic                              stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  sp
);

  // Counter is held at address width with its upper bits forced to zero,
  // so it behaves as a CNT_W-bit counter.
  localparam logic [ADDR_W-1:0] CNT_MASK = ADDR_W'((64'd1 << CNT_W) - 64'd1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              err_q;
  logic [ADDR_W-1:0] code_d;
  logic [ADDR_W-1:0] pc1;
  logic [ADDR_W-1:0] stk_top;
  logic              dispatch;
  logic              decode;
  logic              push;
  logic              pop;
  logic              clr;
  logic              ovf;
  logic              unf;
  a2func_e           fn;

  assign fn       = a2func_e'(a2func);
  assign pc1      = pc_q + ADDR_W'(1);
  assign dispatch = op_look & op_valid;
  assign decode   = reset_l & ~fpkill & ~fpuhold & ~dispatch & busy_q;
  assign push     = decode & (fn == CALL);
  assign pop      = decode & (fn == RET);
  assign clr      = ~reset_l | fpkill | (~fpuhold & dispatch);

  fpu_useq_lstack #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_lstack (
    .clk  (clk),
    .push (push),
    .pop  (pop),
    .clr  (clr),
    .din  (pc1),
    .top  (stk_top),
    .sp   (sp),
    .ovf  (ovf),
    .unf  (unf)
  );

  always_comb begin
    code_d = '0;
    if (!reset_l || fpkill) begin
      code_d = '0;
    end else if (fpuhold) begin
      code_d = pc_q;
    end else if (dispatch) begin
      code_d = mapadd;
    end else if (busy_q) begin
      case (fn)
        CBR:     code_d = cond ? nxcode : pc1;
        LDCNT:   code_d = pc1;
        LOOP:    code_d = (cnt_q != '0) ? nxcode : pc1;
        CALL:    code_d = nxcode;
        RET:     code_d = unf ? '0 : stk_top;
        END:     code_d = '0;
        default: code_d = nxcode;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      pc_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (fpkill) begin
      pc_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (!fpuhold) begin
      pc_q <= code_d;
      if (dispatch) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q) begin
        case (fn)
          LDCNT: cnt_q <= nxcode & CNT_MASK;
          LOOP:  if (cnt_q != '0) cnt_q <= cnt_q - ADDR_W'(1);
          CALL:  if (ovf) err_q <= 1'b1;
          RET:   if (unf) begin
                   err_q  <= 1'b1;
                   busy_q <= 1'b0;
                 end
          END:   busy_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign code_add  = code_d;
  assign rom_en    = ~reset_l | ~fpuhold;
  assign erop      = (fn == END);
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_fpu_useq.sv
module tb_fpu_useq;
  import fpu_useq_pkg::*;

  logic       clk = 1'b0;
  logic       reset_l, fpuhold, fpkill, op_look, op_valid, cond;
  logic [7:0] mapadd, nxcode;
  logic [2:0] a2func;
  logic [7:0] code_add, pc;
  logic       rom_en, busy, erop, stack_err;
  logic [2:0] sp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_useq #(.ADDR_W(8), .STACK_DEPTH(4), .CNT_W(6)) dut (
    .clk(clk), .reset_l(reset_l), .fpuhold(fpuhold), .fpkill(fpkill),
    .op_look(op_look), .op_valid(op_valid), .mapadd(mapadd), .a2func(a2func),
    .nxcode(nxcode), .cond(cond), .code_add(code_add), .rom_en(rom_en),
    .pc(pc), .busy(busy), .erop(erop), .stack_err(stack_err), .sp(sp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (spec rules, queue-based stack) -------
  logic [7:0] m_pc = 0;
  bit         m_busy = 0, m_err = 0;
  int         m_cnt = 0;
  logic [7:0] m_stk[$];

  function automatic logic [7:0] model_step(input bit commit);
    logic [7:0] nx;
    logic [7:0] pc1;
    pc1 = m_pc + 8'd1;
    nx  = 8'd0;
    if (!reset_l) begin
      if (commit) begin m_busy = 0; m_err = 0; m_cnt = 0; m_stk.delete(); end
    end else if (fpkill) begin
      if (commit) begin m_busy = 0; m_cnt = 0; m_stk.delete(); end
    end else if (fpuhold) begin
      nx = m_pc;
    end else if (op_look && op_valid) begin
      nx = mapadd;
      if (commit) begin m_busy = 1; m_cnt = 0; m_stk.delete(); end
    end else if (m_busy) begin
      case (a2func)
        3'd1: nx = cond ? nxcode : pc1;
        3'd2: begin nx = pc1; if (commit) m_cnt = nxcode % 64; end
        3'd3: if (m_cnt != 0) begin nx = nxcode; if (commit) m_cnt--; end
              else nx = pc1;
        3'd4: begin
          nx = nxcode;
          if (commit) begin
            if (m_stk.size() < 4) m_stk.push_back(pc1);
            else m_err = 1;
          end
        end
        3'd5: if (m_stk.size() == 0) begin
                nx = 0;
                if (commit) begin m_err = 1; m_busy = 0; end
              end else begin
                nx = m_stk[$];
                if (commit) void'(m_stk.pop_back());
              end
        3'd7: begin nx = 0; if (commit) m_busy = 0; end
        default: nx = nxcode;
      endcase
    end
    if (commit && !(reset_l && !fpkill && fpuhold)) m_pc = nx;
    return nx;
  endfunction

  // One clock: check combinational outputs before the edge, registered after.
  task automatic cyc();
    logic [7:0] exp;
    #1;
    exp = model_step(1'b0);
    chk("code_add", code_add, exp);
    chk("rom_en", rom_en, (!reset_l || !fpuhold) ? 1 : 0);
    chk("erop", erop, (a2func == 3'd7) ? 1 : 0);
    @(posedge clk);
    void'(model_step(1'b1));
    #1;
    chk("pc", pc, m_pc);
    chk("busy", busy, m_busy);
    chk("sp", sp, m_stk.size());
    chk("stack_err", stack_err, m_err);
  endtask

  task automatic idle_inputs();
    reset_l = 1; fpuhold = 0; fpkill = 0; op_look = 0; op_valid = 0;
    cond = 0; mapadd = 0; a2func = 0; nxcode = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_l = 0;
    cyc();
    reset_l = 1;
  endtask

  task automatic dispatch(input logic [7:0] a);
    op_look = 1; op_valid = 1; mapadd = a; a2func = 0; nxcode = 0;
    cyc();
    op_look = 0; op_valid = 0;
  endtask

  // Microcode ROM for the hand-written sequences, indexed by model pc.
  logic [2:0] rom_fn[256];
  logic [7:0] rom_nx[256];

  task automatic rom_word();
    a2func = rom_fn[m_pc];
    nxcode = rom_nx[m_pc];
  endtask

  task automatic run_rom(input int n);
    for (int i = 0; i < n; i++) begin
      rom_word();
      cyc();
    end
  endtask

  typedef struct {
    bit kill, hold, look, valid;
    logic [7:0] map;
    logic [2:0] fn;
    logic [7:0] nx;
    bit cnd;
    logic [7:0] eca, epc;
    bit ebusy;
    int esp;
    bit eerr;
  } vec_t;

  function automatic vec_t mk(bit k, bit h, bit l, bit v, logic [7:0] m, logic [2:0] f,
                              logic [7:0] n, bit c, logic [7:0] eca, logic [7:0] epc,
                              bit eb, int es, bit ee);
    vec_t r;
    r.kill = k; r.hold = h; r.look = l; r.valid = v; r.map = m; r.fn = f; r.nx = n;
    r.cnd = c; r.eca = eca; r.epc = epc; r.ebusy = eb; r.esp = es; r.eerr = ee;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    int body, v70, saved_sp;
    logic [7:0] saved_pc;

    idle_inputs();
    reset_l = 0;
    for (int i = 0; i < 256; i++) begin rom_fn[i] = 3'd7; rom_nx[i] = 0; end

    // ---------------- table: reset state, function decode, boundaries ----
    tbl.push_back(mk(0,0,1,1,8'h10,SEQ  ,8'h00,0,8'h10,8'h10,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,CALL ,8'h40,0,8'h40,8'h40,1,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,CALL ,8'h60,0,8'h60,8'h60,1,2,0));
    tbl.push_back(mk(0,0,0,0,8'h00,RET  ,8'h00,0,8'h41,8'h41,1,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,RET  ,8'h00,0,8'h11,8'h11,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,CBR  ,8'h80,1,8'h80,8'h80,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,CBR  ,8'h05,0,8'h81,8'h81,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,SEQ  ,8'h33,0,8'h33,8'h33,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,RSVD ,8'h44,0,8'h44,8'h44,1,0,0));
    tbl.push_back(mk(0,0,1,1,8'h2c,END  ,8'h00,0,8'h2c,8'h2c,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,END  ,8'h00,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,SEQ  ,8'h55,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(0,0,1,0,8'h77,SEQ  ,8'h55,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(0,0,1,1,8'h2c,SEQ  ,8'h00,0,8'h2c,8'h2c,1,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,SEQ  ,8'h99,0,8'h2c,8'h2c,1,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,RET  ,8'h00,0,8'h00,8'h00,0,0,1));
    tbl.push_back(mk(0,0,1,1,8'hfe,SEQ  ,8'h00,0,8'hfe,8'hfe,1,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,CBR  ,8'h12,0,8'hff,8'hff,1,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,CBR  ,8'h12,0,8'h00,8'h00,1,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,CALL ,8'h50,0,8'h50,8'h50,1,1,1));
    tbl.push_back(mk(1,0,1,1,8'h66,SEQ  ,8'h00,0,8'h00,8'h00,0,0,1));
    tbl.push_back(mk(0,1,1,1,8'h33,SEQ  ,8'h00,0,8'h00,8'h00,0,0,1));
    tbl.push_back(mk(0,0,0,0,8'h00,LDCNT,8'h07,0,8'h00,8'h00,0,0,1));

    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sp", sp, 0);
    chk("rst_err", stack_err, 0);

    foreach (tbl[i]) begin
      fpkill = tbl[i].kill; fpuhold = tbl[i].hold; op_look = tbl[i].look;
      op_valid = tbl[i].valid; mapadd = tbl[i].map; a2func = tbl[i].fn;
      nxcode = tbl[i].nx; cond = tbl[i].cnd;
      #1;
      chk($sformatf("tbl%0d_code_add", i), code_add, tbl[i].eca);
      cyc();
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].epc);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
      chk($sformatf("tbl%0d_sp", i), sp, tbl[i].esp);
      chk($sformatf("tbl%0d_err", i), stack_err, tbl[i].eerr);
    end
    idle_inputs();

    // ---------------- overflow: five nested calls --------------------------
    for (int a = 8'h80; a < 8'h85; a++) begin rom_fn[a] = CALL; rom_nx[a] = 8'(a + 1); end
    do_reset();
    dispatch(8'h80);
    run_rom(5);
    chk("ovf_sp", sp, 4);
    chk("ovf_err", stack_err, 1);
    chk("ovf_pc", pc, 8'h85);
    run_rom(1);

    // ---------------- loop: LDCNT 3, body, LOOP back -----------------------
    rom_fn[8'h20] = LDCNT; rom_nx[8'h20] = 8'd3;
    rom_fn[8'h21] = SEQ;   rom_nx[8'h21] = 8'h22;
    rom_fn[8'h22] = LOOP;  rom_nx[8'h22] = 8'h21;
    rom_fn[8'h23] = LOOP;  rom_nx[8'h23] = 8'h70;
    rom_fn[8'h24] = END;
    do_reset();
    dispatch(8'h20);
    body = 0; v70 = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      run_rom(1);
      if (pc == 8'h21) body++;
      if (pc == 8'h70) v70++;
    end
    chk("loop_body_count", body, 4);
    chk("loop_cnt_zero", v70, 0);
    chk("loop_done", busy, 0);

    // ---------------- hold for three cycles mid-loop -----------------------
    dispatch(8'h20);
    run_rom(2);
    saved_pc = pc; saved_sp = sp;
    fpuhold = 1;
    for (int i = 0; i < 3; i++) begin
      rom_word();
      #1;
      chk("hold_code_add", code_add, saved_pc);
      chk("hold_rom_en", rom_en, 0);
      cyc();
      chk("hold_pc", pc, saved_pc);
      chk("hold_sp", sp, saved_sp);
    end
    fpuhold = 0;
    for (int i = 0; i < 40 && busy; i++) run_rom(1);
    chk("hold_loop_done", busy, 0);

    // ---------------- kill mid-subroutine at sp=2 --------------------------
    rom_fn[8'h90] = CALL; rom_nx[8'h90] = 8'hc0;
    rom_fn[8'hc0] = CALL; rom_nx[8'hc0] = 8'hc8;
    rom_fn[8'hc8] = SEQ;  rom_nx[8'hc8] = 8'hc8;
    dispatch(8'h90);
    run_rom(2);
    chk("kill_pre_sp", sp, 2);
    fpkill = 1;
    rom_word();
    #1;
    chk("kill_code_add", code_add, 0);
    cyc();
    fpkill = 0;
    chk("kill_sp", sp, 0);
    chk("kill_busy", busy, 0);
    chk("kill_pc", pc, 0);

    // ---------------- reset during LOOP with cnt=5 -------------------------
    rom_fn[8'hb0] = RET;
    rom_fn[8'ha0] = LDCNT; rom_nx[8'ha0] = 8'd5;
    rom_fn[8'ha1] = LOOP;  rom_nx[8'ha1] = 8'ha1;
    dispatch(8'hb0);
    run_rom(1);
    chk("unf_err", stack_err, 1);
    dispatch(8'ha0);
    run_rom(1);
    rom_word();
    reset_l = 0; fpuhold = 1;
    #1;
    chk("rstmid_code_add", code_add, 0);
    chk("rstmid_rom_en", rom_en, 1);
    cyc();
    chk("rstmid_pc", pc, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_sp", sp, 0);
    chk("rstmid_err", stack_err, 0);
    idle_inputs();

    // ---------------- randomized traffic against the model -----------------
    for (int i = 0; i < 3000; i++) begin
      reset_l  = ($urandom_range(0, 99) != 0);
      fpkill   = ($urandom_range(0, 39) == 0);
      fpuhold  = ($urandom_range(0, 5) == 0);
      op_look  = ($urandom_range(0, 7) == 0);
      op_valid = ($urandom_range(0, 3) != 0);
      mapadd   = 8'($urandom);
      a2func   = 3'($urandom);
      nxcode   = 8'($urandom);
      cond     = 1'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
